// File: rtl/score_record_store_pkg.sv
// rtl/score_record_store_pkg.sv - shared play-record types and history-page geometry
package score_record_store_pkg;

    localparam int NAME_LEN          = 8;
    localparam int HISTORY_ROWS      = 9;
    localparam int HISTORY_FIRST_ROW = 2;

    typedef struct packed {
        logic [15:0]           user_id;
        logic [NAME_LEN*8-1:0] chart_name;
        logic [31:0]           score;
    } PlayRecord;

    localparam PlayRecord BLANK_RECORD = '{
        user_id:    16'd0,
        chart_name: {NAME_LEN{8'h20}},
        score:      32'd0
    };

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } store_state_t;

endpackage

// File: rtl/score_record_store_index_map.sv
// rtl/score_record_store_index_map.sv - maps a history screen row to a ring slot, newest first
module record_index_map
    import score_record_store_pkg::*;
#(
    parameter int DEPTH     = HISTORY_ROWS,
    parameter int FIRST_ROW = HISTORY_FIRST_ROW,
    localparam int PTR_W    = $clog2(DEPTH)
) (
    input  logic [7:0]       read_record_id,
    input  logic [PTR_W-1:0] wr_ptr,
    input  logic [3:0]       record_count,
    output logic [PTR_W-1:0] slot,
    output logic             hit
);

    logic [9:0]     row_diff;
    logic [PTR_W:0] slot_sum;

    // Bit 9 of row_diff is the borrow: rows above FIRST_ROW on screen never hit.
    always_comb begin
        row_diff = {2'b00, read_record_id} - 10'(FIRST_ROW);
        hit      = 1'b0;
        slot     = '0;
        slot_sum = '0;
        if (!row_diff[9] && (row_diff[8:0] < {5'b00000, record_count})) begin
            hit      = 1'b1;
            slot_sum = {1'b0, wr_ptr} + (PTR_W+1)'(DEPTH - 1) - row_diff[PTR_W:0];
            if (slot_sum >= (PTR_W+1)'(DEPTH)) begin
                slot = PTR_W'(slot_sum - (PTR_W+1)'(DEPTH));
            end else begin
                slot = slot_sum[PTR_W-1:0];
            end
        end
    end

endmodule

// File: rtl/score_record_store.sv
// rtl/score_record_store.sv - ring buffer of the last DEPTH play records served newest-first
module score_record_store
    import score_record_store_pkg::*;
#(
    parameter int DEPTH     = HISTORY_ROWS,
    parameter int FIRST_ROW = HISTORY_FIRST_ROW
) (
    input  logic        prog_clk,
    input  logic        rst_n,
    input  logic        wr_valid,
    output logic        wr_ready,
    input  PlayRecord   wr_record,
    input  logic        clear,
    input  logic [7:0]  read_record_id,
    output PlayRecord   record_data,
    output logic [3:0]  record_count,
    output logic [15:0] total_plays
);

    localparam int               PTR_W     = $clog2(DEPTH);
    localparam logic [PTR_W-1:0] LAST_SLOT = PTR_W'(DEPTH - 1);
    localparam logic [3:0]       COUNT_MAX = 4'(DEPTH);

    store_state_t     state_q, state_d;
    logic [PTR_W-1:0] sweep_q, sweep_d;
    logic [PTR_W-1:0] wr_ptr_q;
    logic [3:0]       count_q;
    logic [15:0]      total_q;
    logic             wr_ready_q;
    PlayRecord        record_data_q;
    logic             sweep_write;
    logic             wr_accept;
    logic [PTR_W-1:0] rd_slot;
    logic             rd_hit;

    // No reset on storage: the CLEAR sweep is what initialises it.
    PlayRecord mem [DEPTH];

    record_index_map #(
        .DEPTH     (DEPTH),
        .FIRST_ROW (FIRST_ROW)
    ) u_index_map (
        .read_record_id (read_record_id),
        .wr_ptr         (wr_ptr_q),
        .record_count   (count_q),
        .slot           (rd_slot),
        .hit            (rd_hit)
    );

    always_comb begin
        state_d     = state_q;
        sweep_d     = sweep_q;
        sweep_write = 1'b0;
        wr_accept   = 1'b0;
        case (state_q)
            ST_CLEAR: begin
                sweep_write = 1'b1;
                if (clear) begin
                    sweep_d = '0;
                end else if (sweep_q == LAST_SLOT) begin
                    state_d = ST_IDLE;
                    sweep_d = '0;
                end else begin
                    sweep_d = sweep_q + 1'b1;
                end
            end
            ST_IDLE: begin
                // A clear in the same cycle as a write drops the write.
                if (clear) begin
                    state_d = ST_CLEAR;
                    sweep_d = '0;
                end else begin
                    wr_accept = wr_valid && wr_ready_q;
                end
            end
            default: begin
                state_d = ST_CLEAR;
                sweep_d = '0;
            end
        endcase
    end

    always_ff @(posedge prog_clk) begin
        if (!rst_n) begin
            state_q    <= ST_CLEAR;
            sweep_q    <= '0;
            wr_ready_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            sweep_q    <= sweep_d;
            wr_ready_q <= (state_d == ST_IDLE);
        end
    end

    always_ff @(posedge prog_clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            count_q  <= '0;
            total_q  <= '0;
        end else if ((state_q == ST_IDLE) && clear) begin
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else if (wr_accept) begin
            wr_ptr_q <= (wr_ptr_q == LAST_SLOT) ? '0 : wr_ptr_q + 1'b1;
            count_q  <= (count_q == COUNT_MAX) ? COUNT_MAX : count_q + 1'b1;
            total_q  <= total_q + 16'd1;
        end
    end

    always_ff @(posedge prog_clk) begin
        if (rst_n) begin
            if (sweep_write) begin
                mem[sweep_q] <= BLANK_RECORD;
            end else if (wr_accept) begin
                mem[wr_ptr_q] <= wr_record;
            end
        end
    end

    // Read sees pre-write pointer, count and memory contents.
    always_ff @(posedge prog_clk) begin
        if (!rst_n) begin
            record_data_q <= BLANK_RECORD;
        end else if ((state_q == ST_IDLE) && rd_hit) begin
            record_data_q <= mem[rd_slot];
        end else begin
            record_data_q <= BLANK_RECORD;
        end
    end

    assign wr_ready     = wr_ready_q;
    assign record_data  = record_data_q;
    assign record_count = count_q;
    assign total_plays  = total_q;

endmodule

// File: tb/tb_score_record_store.sv
// tb/tb_score_record_store.sv - randomized self-checking bench for score_record_store
module tb_score_record_store;
    import score_record_store_pkg::*;

    localparam int DEPTH     = HISTORY_ROWS;
    localparam int FIRST_ROW = HISTORY_FIRST_ROW;

    logic        prog_clk = 1'b0;
    logic        rst_n;
    logic        wr_valid;
    logic        wr_ready;
    PlayRecord   wr_record;
    logic        clear;
    logic [7:0]  read_record_id;
    PlayRecord   record_data;
    logic [3:0]  record_count;
    logic [15:0] total_plays;

    PlayRecord hist[$];
    int        m_clear_left;
    int        m_total;
    PlayRecord exp_data;
    int        checks;
    int        failures;

    always #5 prog_clk = ~prog_clk;

    score_record_store #(
        .DEPTH     (DEPTH),
        .FIRST_ROW (FIRST_ROW)
    ) dut (
        .prog_clk       (prog_clk),
        .rst_n          (rst_n),
        .wr_valid       (wr_valid),
        .wr_ready       (wr_ready),
        .wr_record      (wr_record),
        .clear          (clear),
        .read_record_id (read_record_id),
        .record_data    (record_data),
        .record_count   (record_count),
        .total_plays    (total_plays)
    );

    function automatic PlayRecord make_rec(input int user, input int score);
        PlayRecord r;
        r.user_id = 16'(user);
        r.score   = 32'(score);
        for (int i = 0; i < NAME_LEN; i++) r.chart_name[i*8 +: 8] = 8'(8'h41 + $urandom_range(0, 25));
        return r;
    endfunction

    // Behavioural model: history is a newest-first list; CLEAR is a countdown.
    task automatic cycle();
        int k;
        if (!rst_n) begin
            hist.delete();
            m_total      = 0;
            m_clear_left = DEPTH;
            exp_data     = BLANK_RECORD;
        end else begin
            k = int'(read_record_id) - FIRST_ROW;
            if (m_clear_left == 0 && k >= 0 && k < int'(hist.size())) exp_data = hist[k];
            else exp_data = BLANK_RECORD;
            if (m_clear_left > 0) begin
                m_clear_left = clear ? DEPTH : m_clear_left - 1;
            end else if (clear) begin
                hist.delete();
                m_clear_left = DEPTH;
            end else if (wr_valid) begin
                hist.push_front(wr_record);
                if (hist.size() > DEPTH) void'(hist.pop_back());
                m_total = (m_total + 1) % 65536;
            end
        end
        @(posedge prog_clk);
        #1;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0; wr_valid = 1'b0; clear = 1'b0; read_record_id = 8'd0;
        cycle(); cycle();
        rst_n = 1'b1;
        repeat (DEPTH) cycle();
    endtask

    task automatic write_rec(input PlayRecord r);
        wr_valid = 1'b1; wr_record = r;
        cycle();
        wr_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; wr_valid = 1'b0; clear = 1'b0; read_record_id = 8'd2;
        wr_record = BLANK_RECORD;
        cycle(); cycle();
        checks++; if (wr_ready !== 1'b0) begin failures++; $display("FAIL reset_ready got=%b exp=0", wr_ready); end
        checks++; if (record_count !== 4'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", record_count); end
        checks++; if (total_plays !== 16'd0) begin failures++; $display("FAIL reset_total got=%0d exp=0", total_plays); end
        checks++; if (record_data !== BLANK_RECORD) begin failures++; $display("FAIL reset_data got=%h exp=%h", record_data, BLANK_RECORD); end
        rst_n = 1'b1;
        for (int i = 0; i <= DEPTH; i++) begin
            checks++;
            if (wr_ready !== (i == DEPTH)) begin failures++; $display("FAIL reset_sweep_ready[%0d] got=%b exp=%b", i, wr_ready, (i == DEPTH)); end
            if (i < DEPTH) cycle();
        end
        for (int r = 0; r <= 10; r++) begin
            read_record_id = 8'(r);
            cycle();
            checks++;
            if (record_data !== BLANK_RECORD) begin failures++; $display("FAIL reset_read[%0d] got=%h exp=%h", r, record_data, BLANK_RECORD); end
        end
        checks++; if (record_count !== 4'd0) begin failures++; $display("FAIL reset_count_idle got=%0d exp=0", record_count); end
    endtask

    task automatic test_three_writes();
        for (int u = 1; u <= 3; u++) write_rec(make_rec(u, u * 100));
        read_record_id = 8'd2; cycle();
        checks++;
        if (record_data.user_id !== 16'd3 || record_data.score !== 32'd300 || record_data !== exp_data) begin
            failures++; $display("FAIL three_row2 got=%h exp_user=3 exp_score=300", record_data);
        end
        read_record_id = 8'd4; cycle();
        checks++;
        if (record_data.user_id !== 16'd1 || record_data.score !== 32'd100 || record_data !== exp_data) begin
            failures++; $display("FAIL three_row4 got=%h exp_user=1 exp_score=100", record_data);
        end
        read_record_id = 8'd5; cycle();
        checks++; if (record_data !== BLANK_RECORD) begin failures++; $display("FAIL three_row5 got=%h exp=%h", record_data, BLANK_RECORD); end
        checks++; if (record_count !== 4'd3) begin failures++; $display("FAIL three_count got=%0d exp=3", record_count); end
    endtask

    task automatic test_wrap();
        apply_reset();
        for (int u = 1; u <= 11; u++) write_rec(make_rec(u, $urandom_range(0, 99999)));
        checks++; if (record_count !== 4'd9) begin failures++; $display("FAIL wrap_count got=%0d exp=9", record_count); end
        checks++; if (total_plays !== 16'd11) begin failures++; $display("FAIL wrap_total got=%0d exp=11", total_plays); end
        read_record_id = 8'd2; cycle();
        checks++; if (record_data.user_id !== 16'd11 || record_data !== exp_data) begin failures++; $display("FAIL wrap_row2 got=%h exp_user=11", record_data); end
        read_record_id = 8'd10; cycle();
        checks++; if (record_data.user_id !== 16'd3 || record_data !== exp_data) begin failures++; $display("FAIL wrap_row10 got=%h exp_user=3", record_data); end
        read_record_id = 8'd11; cycle();
        checks++; if (record_data !== BLANK_RECORD) begin failures++; $display("FAIL wrap_row11 got=%h exp=%h", record_data, BLANK_RECORD); end
        read_record_id = 8'hFF; cycle();
        checks++; if (record_data !== BLANK_RECORD) begin failures++; $display("FAIL wrap_rowFF got=%h exp=%h", record_data, BLANK_RECORD); end
    endtask

    task automatic test_same_cycle();
        apply_reset();
        write_rec(make_rec(7, 70));
        write_rec(make_rec(8, 80));
        read_record_id = 8'd2;
        write_rec(make_rec(9, 90));
        checks++; if (record_data.user_id !== 16'd8 || record_data !== exp_data) begin failures++; $display("FAIL rbw_old got=%h exp_user=8", record_data); end
        cycle();
        checks++; if (record_data.user_id !== 16'd9 || record_data !== exp_data) begin failures++; $display("FAIL rbw_new got=%h exp_user=9", record_data); end
        checks++; if (record_count !== 4'd3) begin failures++; $display("FAIL rbw_count got=%0d exp=3", record_count); end
    endtask

    task automatic test_clear();
        apply_reset();
        for (int u = 1; u <= 5; u++) write_rec(make_rec(u, u));
        read_record_id = 8'd2; clear = 1'b1; wr_valid = 1'b1; wr_record = make_rec(42, 4242);
        cycle();
        clear = 1'b0;
        checks++; if (record_data.user_id !== 16'd5 || record_data !== exp_data) begin failures++; $display("FAIL clear_cycle_read got=%h exp_user=5", record_data); end
        for (int i = 0; i < DEPTH; i++) begin
            checks++; if (wr_ready !== 1'b0) begin failures++; $display("FAIL clear_ready[%0d] got=%b exp=0", i, wr_ready); end
            checks++; if (record_count !== 4'd0) begin failures++; $display("FAIL clear_count[%0d] got=%0d exp=0", i, record_count); end
            cycle();
            checks++; if (record_data !== BLANK_RECORD) begin failures++; $display("FAIL clear_read[%0d] got=%h exp=%h", i, record_data, BLANK_RECORD); end
        end
        checks++; if (wr_ready !== 1'b1) begin failures++; $display("FAIL clear_done_ready got=%b exp=1", wr_ready); end
        cycle();
        wr_valid = 1'b0;
        checks++; if (record_count !== 4'd1) begin failures++; $display("FAIL clear_held_write got=%0d exp=1", record_count); end
        checks++; if (total_plays !== 16'd6) begin failures++; $display("FAIL clear_total got=%0d exp=6", total_plays); end
        cycle();
        checks++; if (record_data.user_id !== 16'd42 || record_data !== exp_data) begin failures++; $display("FAIL clear_first_rec got=%h exp_user=42", record_data); end
    endtask

    task automatic test_reset_mid_sweep();
        apply_reset();
        for (int u = 1; u <= 3; u++) write_rec(make_rec(u, u));
        clear = 1'b1; cycle(); clear = 1'b0;
        repeat (4) cycle();
        rst_n = 1'b0; cycle(); rst_n = 1'b1;
        checks++; if (total_plays !== 16'd0) begin failures++; $display("FAIL midreset_total got=%0d exp=0", total_plays); end
        checks++; if (record_count !== 4'd0) begin failures++; $display("FAIL midreset_count got=%0d exp=0", record_count); end
        for (int i = 0; i <= DEPTH; i++) begin
            checks++;
            if (wr_ready !== (i == DEPTH)) begin failures++; $display("FAIL midreset_ready[%0d] got=%b exp=%b", i, wr_ready, (i == DEPTH)); end
            if (i < DEPTH) cycle();
        end
    endtask

    task automatic test_random();
        int uid = 1000;
        for (int n = 0; n < 600; n++) begin
            wr_valid  = ($urandom_range(0, 2) != 0);
            wr_record = make_rec(uid, $urandom);
            uid++;
            clear     = ($urandom_range(0, 59) == 0);
            read_record_id = ($urandom_range(0, 9) == 0) ? 8'($urandom) : 8'($urandom_range(0, 13));
            cycle();
            checks++; if (record_data !== exp_data) begin failures++; $display("FAIL rand_data[%0d] got=%h exp=%h", n, record_data, exp_data); end
            checks++; if (wr_ready !== (m_clear_left == 0)) begin failures++; $display("FAIL rand_ready[%0d] got=%b exp=%b", n, wr_ready, (m_clear_left == 0)); end
            checks++; if (record_count !== 4'(hist.size())) begin failures++; $display("FAIL rand_count[%0d] got=%0d exp=%0d", n, record_count, hist.size()); end
            checks++; if (total_plays !== 16'(m_total)) begin failures++; $display("FAIL rand_total[%0d] got=%0d exp=%0d", n, total_plays, m_total); end
        end
        wr_valid = 1'b0; clear = 1'b0;
    endtask

    initial begin
        checks = 0;
        failures = 0;
        test_reset();
        test_three_writes();
        test_wrap();
        test_same_cycle();
        test_clear();
        test_reset_mid_sweep();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/score_record_store.md
# score_record_store

Ring-buffer store of the last DEPTH completed play records, sitting directly upstream of the score-history page. The game page pushes one `PlayRecord` per finished song through a valid/ready write port. The history page sweeps its screen rows through `read_record_id` and receives the matching record one cycle later. Entries are served newest-first, and rows with no stored record return a blank record.

## Interface
Parameters:
- `DEPTH`, 9: number of records retained; equals the number of history rows.
- `FIRST_ROW`, 2: screen row that maps to the newest record.

Ports:
- `prog_clk`  in  1: program clock; the only clock.
- `rst_n`  in  1: synchronous reset, active-low.
- `wr_valid`  in  1: writer presents `wr_record`.
- `wr_ready`  out  1: store can accept a write.
- `wr_record`  in  `PlayRecord`: record to store (`user_id`, `chart_name`, `score`).
- `clear`  in  1: single-cycle request to erase all records.
- `read_record_id`  in  byte: screen row requested by the history page.
- `record_data`  out  `PlayRecord`: record for the previous cycle's `read_record_id`.
- `record_count`  out  4: number of valid records, 0..DEPTH.
- `total_plays`  out  16: records accepted since reset; wraps.

## Operation
- State machine has two states.
  - CLEAR: blank-write one slot per cycle, slot 0..DEPTH-1. `wr_ready`=0.
  - IDLE: normal operation. `wr_ready`=1.
- Reset (`rst_n`=0 at a clock edge):
  - `wr_ptr`=0, `record_count`=0, `total_plays`=0, `record_data`=BLANK, `wr_ready`=0, state CLEAR with sweep index 0.
  - Reset mid-sweep restarts the sweep.
- BLANK record: `user_id`=0, `chart_name` all spaces (`NAME_LEN` chars), `score`=0.
- CLEAR lasts exactly DEPTH cycles, then goes to IDLE.
- `clear`=1 in IDLE: enter CLEAR, `record_count`=0, `wr_ptr`=0.
- `clear`=1 in CLEAR: restart the sweep at index 0.
- Write accepted when `wr_valid` && `wr_ready`:
  - `mem[wr_ptr]`=`wr_record`.
  - `wr_ptr`=(`wr_ptr`+1) mod DEPTH.
  - `record_count`=min(`record_count`+1, DEPTH).
  - `total_plays`+=1, wrapping at 2^16.
- Buffer full: writing overwrites the oldest entry; `record_count` stays at DEPTH.
- `clear` and an accepted write in the same cycle: `clear` wins and the write is dropped. The writer has already seen `wr_ready`=1, so the drop is documented; the game page never issues both together.
- Read mapping:
  - k = `read_record_id` − FIRST_ROW.
  - If 0 ≤ k < `record_count`: slot = (`wr_ptr` − 1 − k) mod DEPTH, output `mem[slot]`.
  - Otherwise, including `read_record_id` < FIRST_ROW and negative or large byte values: output BLANK.
- During CLEAR, all reads return BLANK.

## Timing
- Read latency is 1 cycle: `record_data` is registered from the `read_record_id` sampled at the same edge.
- Read and write in the same cycle are read-before-write: the read uses the pre-write `wr_ptr`, `record_count` and memory contents.
- `wr_ready` is a registered function of state only. It never depends combinationally on `wr_valid`.
- The writer holds `wr_valid` and `wr_record` stable until it sees `wr_ready`. The store takes at most one record per cycle.
- After reset is released, the first write can be accepted at cycle DEPTH.

## Structure
- In the shared header:
  - `PlayRecord` typedef and `NAME_LEN`.
  - A `BLANK_RECORD` constant.
  - `HISTORY_ROWS` (=DEPTH) and `HISTORY_FIRST_ROW` (=FIRST_ROW), shared with the history page.
- Storage: a DEPTH-entry `PlayRecord` array with no reset, initialised only by the CLEAR sweep.
- One sub-module: `record_index_map`. It is combinational and takes (`read_record_id`, `wr_ptr`, `record_count`) to produce (`slot`, `hit`), including the mod-DEPTH wrap.

## Test plan
- Reset:
  - Hold `rst_n`=0 for 2 cycles, then release.
  - `wr_ready`=0 for 9 cycles, then 1.
  - `record_count`=0.
  - Reading rows 0..10 returns BLANK.
- Three writes:
  - Write users 1, 2, 3 with scores 100, 200, 300.
  - Read row 2 → user 3 / 300; row 4 → user 1 / 100; row 5 → BLANK.
  - `record_count`=3.
- Wrap:
  - Write 11 records, users 1..11.
  - `record_count`=9, `total_plays`=11.
  - Row 2 → user 11; row 10 → user 3; row 11 → BLANK.
- Same-cycle read and write:
  - With 2 records stored, read row 2 while writing user 9.
  - Next cycle `record_data`=old newest.
  - A re-read of row 2 returns user 9.
- Clear:
  - Pulse `clear` with 5 records stored.
  - `wr_ready`=0 for 9 cycles, reads return BLANK, `record_count`=0.
  - A held `wr_valid` is accepted on the first IDLE cycle.
- Reset mid-sweep:
  - Assert `rst_n`=0 at sweep index 4.
  - The sweep restarts and takes a full 9 cycles after release.
  - `total_plays`=0.
